// File: rtl/updown_counter.sv
// Up/down counter over the range [MIN,MAX] with a runtime step.
// Past a limit it either wraps modulo SPAN or clamps (SATURATE=1).
// The overflow/underflow outputs are registered one-cycle pulses.
// The at_max/at_min/match flags decode the registered count directly.
module updown_counter #(
  parameter int NBITS     = 16,
  parameter int MIN       = 0,
  parameter int MAX       = 2**NBITS-1,
  parameter int STEP_BITS = 8,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 dir,
  input  logic [STEP_BITS-1:0] step,
  input  logic                 load,
  input  logic [NBITS-1:0]     load_val,
  input  logic [NBITS-1:0]     cmp_val,
  output logic [NBITS-1:0]     count,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 at_max,
  output logic                 at_min,
  output logic                 match
);

  // The extra headroom bits keep count+step and count-step exact.
  // The sign bit means a result below MIN, including negative, compares correctly.
  localparam int W = NBITS + STEP_BITS + 2;
  localparam logic signed [W-1:0] MIN_W  = W'(MIN);
  localparam logic signed [W-1:0] MAX_W  = W'(MAX);
  localparam logic signed [W-1:0] SPAN_W = W'(MAX - MIN + 1);

  // Reject an empty, negative or unrepresentable range at elaboration.
  if (MIN >= MAX || MIN < 0 || longint'(MAX) > ((longint'(1) << NBITS) - 1)) begin : g_bad_range
    $fatal(1, "updown_counter: illegal range MIN=%0d MAX=%0d NBITS=%0d", MIN, MAX, NBITS);
  end

  logic [NBITS-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic signed [W-1:0] count_x, step_x, load_x, s_eff, nxt;

  // Next-state logic. The update priority is clr > load > en > hold.
  // Both pulse flags default low, so a flag never survives past one cycle.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    count_x = signed'({{(W-NBITS){1'b0}}, count_q});
    step_x  = signed'({{(W-STEP_BITS){1'b0}}, step});
    load_x  = signed'({{(W-NBITS){1'b0}}, load_val});
    s_eff   = (step_x > SPAN_W) ? SPAN_W : step_x;
    nxt     = count_x;
    if (clr) begin
      count_d = NBITS'(MIN);
    end else if (load) begin
      if (load_x > MAX_W)      count_d = NBITS'(MAX);
      else if (load_x < MIN_W) count_d = NBITS'(MIN);
      else                     count_d = load_val;
    end else if (en) begin
      if (!dir) begin
        nxt = count_x + s_eff;
        if (nxt > MAX_W) begin
          ovf_d = 1'b1;
          nxt   = (SATURATE != 0) ? MAX_W : nxt - SPAN_W;
        end
      end else begin
        nxt = count_x - s_eff;
        if (nxt < MIN_W) begin
          unf_d = 1'b1;
          nxt   = (SATURATE != 0) ? MIN_W : nxt + SPAN_W;
        end
      end
      count_d = nxt[NBITS-1:0];
    end
  end

  // State register. Reset overrides every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= NBITS'(MIN);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign at_max    = (count_q == NBITS'(MAX));
  assign at_min    = (count_q == NBITS'(MIN));
  assign match     = (count_q == cmp_val);

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter with NBITS=8, MIN=10, MAX=20.
// A wrap instance and a saturating instance share the same stimulus.
module tb_updown_counter;
  logic       clk = 1'b0;
  logic       rst, clr, en, dir, load;
  logic [7:0] step, load_val, cmp_val;
  logic [7:0] w_count, s_count;
  logic       w_ovf, w_unf, w_amax, w_amin, w_match;
  logic       s_ovf, s_unf, s_amax, s_amin, s_match;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  updown_counter #(.NBITS(8), .MIN(10), .MAX(20), .STEP_BITS(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .step(step),
    .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .count(w_count), .overflow(w_ovf), .underflow(w_unf),
    .at_max(w_amax), .at_min(w_amin), .match(w_match));

  updown_counter #(.NBITS(8), .MIN(10), .MAX(20), .STEP_BITS(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .dir(dir), .step(step),
    .load(load), .load_val(load_val), .cmp_val(cmp_val),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf),
    .at_max(s_amax), .at_min(s_amin), .match(s_match));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle so the outputs are sampled away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check the count and both pulse flags of the wrap and saturating instances.
  task automatic both(input string tag, input int wc, input int wo, input int wu,
                      input int sc, input int so, input int su);
    chk({tag, " w.count"}, int'(w_count), wc);
    chk({tag, " w.ovf"},   int'(w_ovf),   wo);
    chk({tag, " w.unf"},   int'(w_unf),   wu);
    chk({tag, " s.count"}, int'(s_count), sc);
    chk({tag, " s.ovf"},   int'(s_ovf),   so);
    chk({tag, " s.unf"},   int'(s_unf),   su);
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = 8'(v); en = 1'b0;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b1; dir = 1'b0; step = 8'd3;
    load = 1'b1; load_val = 8'd17; cmp_val = 8'd0;
    cyc();
    both("reset", 10, 0, 0, 10, 0, 0);
    chk("reset at_min", int'(w_amin), 1);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // Upward wrap versus clamp, starting from 18 with step 5.
    do_load(18);
    both("load18", 18, 0, 0, 18, 0, 0);
    en = 1'b1; dir = 1'b0; step = 8'd5;
    cyc();
    both("up1", 12, 1, 0, 20, 1, 0);
    chk("up1 s.at_max", int'(s_amax), 1);
    cyc();
    both("up2", 17, 0, 0, 20, 1, 0);
    chk("up2 s.at_max", int'(s_amax), 1);
    en = 1'b0;
    cyc();
    both("idle", 17, 0, 0, 20, 0, 0);

    // Downward wrap versus clamp, starting from 12.
    do_load(12);
    en = 1'b1; dir = 1'b1; step = 8'd5;
    cyc();
    both("dn1", 18, 0, 1, 10, 0, 1);
    step = 8'd2;
    cyc();
    both("dn2", 16, 0, 0, 10, 0, 1);
    chk("dn2 s.at_min", int'(s_amin), 1);

    // A load wins over en, and the loaded value is clamped into range.
    load = 1'b1; load_val = 8'd25; en = 1'b1; dir = 1'b0; step = 8'd1;
    cyc();
    both("load25", 20, 0, 0, 20, 0, 0);
    load_val = 8'd3;
    cyc();
    both("load3", 10, 0, 0, 10, 0, 0);
    chk("load3 at_min", int'(w_amin), 1);
    load = 1'b0; en = 1'b0;

    // An oversize step is limited to SPAN=11.
    do_load(15);
    en = 1'b1; dir = 1'b0; step = 8'd200;
    cyc();
    both("bigstep", 15, 1, 0, 20, 1, 0);

    // Landing exactly on MAX raises no overflow.
    do_load(15);
    en = 1'b1; step = 8'd5;
    cyc();
    both("exact", 20, 0, 0, 20, 0, 0);
    chk("exact at_max", int'(w_amax), 1);

    // A zero step holds the count.
    step = 8'd0;
    cyc();
    both("step0", 20, 0, 0, 20, 0, 0);

    // clr beats load and en, even when en alone would overflow.
    clr = 1'b1; load = 1'b1; load_val = 8'd14; step = 8'd5;
    cyc();
    both("clr", 10, 0, 0, 10, 0, 0);
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // Reset in mid-count discards a pending load.
    do_load(14);
    en = 1'b1; dir = 1'b0; step = 8'd1;
    cyc();
    both("cnt15", 15, 0, 0, 15, 0, 0);
    rst = 1'b1; load = 1'b1; load_val = 8'd18;
    cyc();
    both("midrst", 10, 0, 0, 10, 0, 0);
    rst = 1'b0; load = 1'b0; cmp_val = 8'd11;
    cyc();
    both("resume", 11, 0, 0, 11, 0, 0);
    chk("resume match", int'(w_match), 1);
    cmp_val = 8'd12;
    #1;
    chk("nomatch", int'(s_match), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
